mure_iretire_sequencer: RTL and testbench

Drains the uop FIFO of the trace connector and groups consecutive retired instructions into E-trace blocks. Each block is described by a start address, a retired-halfword count (`iretire`), the size of its last instruction, a closing `itype` and a privilege level. The block sits between the uop FIFO (upstream) and the trace encoder input (downstream). It sequences FIFO pops with an IDLE/COUNT state machine (`state_e`) and applies valid/ready backpressure from the encoder.

---
 rtl/mure_iretire_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_mure_iretire_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mure_iretire_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mure_iretire_sequencer                                                     |
// | Drains the trace uop FIFO into E-trace instruction blocks (iaddr/iretire). |
// | Optional macro: MURE_PRIV_SPLIT_EN closes a block on a privilege change.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package mure_pkg;

   localparam int XLEN        = 32;
   localparam int IRETIRE_LEN = 14;
   localparam int ITYPE_LEN   = 4;
   localparam int PRIV_LEN    = 2;

   typedef enum logic [ITYPE_LEN-1:0] {
      STD  = 4'd0,
      EXC  = 4'd1,
      INT  = 4'd2,
      ERET = 4'd3,
      NTB  = 4'd4,
      TB   = 4'd5,
      UIJ  = 4'd6
   } itype_e;

   typedef struct packed {
      logic                valid;
      logic [XLEN-1:0]     pc;
      itype_e              itype;
      logic                compressed;
      logic [PRIV_LEN-1:0] priv;
   } uop_entry_s;

endpackage

module mure_iretire_sequencer #(
   parameter int XLEN        = mure_pkg::XLEN,
   parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           fifo_empty_i,
   input  mure_pkg::uop_entry_s           fifo_entry_i,
   output logic                           fifo_pop_o,
   output logic                           block_valid_o,
   input  logic                           block_ready_i,
   output logic [XLEN-1:0]                iaddr_o,
   output logic [IRETIRE_LEN-1:0]         iretire_o,
   output logic                           ilastsize_o,
   output logic [mure_pkg::ITYPE_LEN-1:0] itype_o,
   output logic [mure_pkg::PRIV_LEN-1:0]  priv_o
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   localparam logic [IRETIRE_LEN:0] ACC_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};
   localparam logic [IRETIRE_LEN:0] MAX_SZ  = (IRETIRE_LEN+1)'(2);

   state_e                           state_q, state_d;
   logic [XLEN-1:0]                  iaddr_q, iaddr_d;
   logic [IRETIRE_LEN-1:0]           acc_q, acc_d;
   logic                             last_q, last_d;
   logic [mure_pkg::PRIV_LEN-1:0]    priv_q, priv_d;

   logic                             valid_q;
   logic                             emit_d;
   logic [XLEN-1:0]                  out_iaddr_q, out_iaddr_d;
   logic [IRETIRE_LEN-1:0]           out_iretire_q, out_iretire_d;
   logic                             out_last_q, out_last_d;
   logic [mure_pkg::ITYPE_LEN-1:0]   out_itype_q, out_itype_d;
   logic [mure_pkg::PRIV_LEN-1:0]    out_priv_q, out_priv_d;

   logic                             slot_free;
   logic                             sat_close;
   logic                             priv_close;
   logic                             force_close;
   logic                             take;
   logic                             entry_closes;
   logic [IRETIRE_LEN-1:0]           entry_sz;
   logic [IRETIRE_LEN-1:0]           acc_sum;
   logic [XLEN-1:0]                  entry_pc;

   assign slot_free    = !valid_q || block_ready_i;
   assign entry_sz     = fifo_entry_i.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
   assign entry_pc     = XLEN'(fifo_entry_i.pc);
   assign entry_closes = (fifo_entry_i.itype != mure_pkg::STD);
   assign acc_sum      = acc_q + entry_sz;

   // Close before the counter could overflow on a 32-bit instruction.
   assign sat_close = (state_q == COUNT) && (({1'b0, acc_q} + MAX_SZ) > ACC_MAX);

`ifdef MURE_PRIV_SPLIT_EN
   assign priv_close = (state_q == COUNT) && !fifo_empty_i && fifo_entry_i.valid
                       && (fifo_entry_i.priv != priv_q);
`else
   assign priv_close = 1'b0;
`endif

   assign force_close = !rst_i && slot_free && (sat_close || priv_close);
   assign fifo_pop_o  = !rst_i && !fifo_empty_i && slot_free && !force_close;
   assign take        = fifo_pop_o && fifo_entry_i.valid;

   always_comb begin
      state_d       = state_q;
      iaddr_d       = iaddr_q;
      acc_d         = acc_q;
      last_d        = last_q;
      priv_d        = priv_q;
      emit_d        = 1'b0;
      out_iaddr_d   = iaddr_q;
      out_iretire_d = acc_q;
      out_last_d    = last_q;
      out_itype_d   = mure_pkg::STD;
      out_priv_d    = priv_q;

      if (force_close) begin
         // Forced close: the head entry stays put and opens the next block.
         emit_d  = 1'b1;
         state_d = IDLE;
         acc_d   = '0;
      end else if (take) begin
         case (state_q)
            IDLE: begin
               iaddr_d = entry_pc;
               acc_d   = entry_sz;
               last_d  = !fifo_entry_i.compressed;
               priv_d  = fifo_entry_i.priv;
               if (entry_closes) begin
                  emit_d        = 1'b1;
                  out_iaddr_d   = entry_pc;
                  out_iretire_d = entry_sz;
                  out_last_d    = !fifo_entry_i.compressed;
                  out_itype_d   = fifo_entry_i.itype;
                  out_priv_d    = fifo_entry_i.priv;
                  acc_d         = '0;
               end else begin
                  state_d = COUNT;
               end
            end
            COUNT: begin
               acc_d  = acc_sum;
               last_d = !fifo_entry_i.compressed;
               if (entry_closes) begin
                  emit_d        = 1'b1;
                  out_iretire_d = acc_sum;
                  out_last_d    = !fifo_entry_i.compressed;
                  out_itype_d   = fifo_entry_i.itype;
                  state_d       = IDLE;
                  acc_d         = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         iaddr_q <= '0;
         acc_q   <= '0;
         last_q  <= 1'b0;
         priv_q  <= '0;
      end else begin
         state_q <= state_d;
         iaddr_q <= iaddr_d;
         acc_q   <= acc_d;
         last_q  <= last_d;
         priv_q  <= priv_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q       <= 1'b0;
         out_iaddr_q   <= '0;
         out_iretire_q <= '0;
         out_last_q    <= 1'b0;
         out_itype_q   <= mure_pkg::STD;
         out_priv_q    <= '0;
      end else if (emit_d) begin
         valid_q       <= 1'b1;
         out_iaddr_q   <= out_iaddr_d;
         out_iretire_q <= out_iretire_d;
         out_last_q    <= out_last_d;
         out_itype_q   <= out_itype_d;
         out_priv_q    <= out_priv_d;
      end else if (block_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign block_valid_o = valid_q;
   assign iaddr_o       = out_iaddr_q;
   assign iretire_o     = out_iretire_q;
   assign ilastsize_o   = out_last_q;
   assign itype_o       = out_itype_q;
   assign priv_o        = out_priv_q;

endmodule

`default_nettype wire

// File: tb/tb_mure_iretire_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mure_iretire_sequencer                                                  |
// | Directed and random stimulus against a stream-level block model.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_mure_iretire_sequencer;
   import mure_pkg::*;

   localparam int TB_IRL  = 4;
   localparam int ACC_MAX = (1 << TB_IRL) - 1;

   typedef struct {
      logic [31:0] iaddr;
      int          iretire;
      logic        last;
      logic [3:0]  itype;
      logic [1:0]  priv;
   } blk_t;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              fifo_empty_i;
   uop_entry_s        fifo_entry_i;
   logic              fifo_pop_o;
   logic              block_valid_o;
   logic              block_ready_i;
   logic [31:0]       iaddr_o;
   logic [TB_IRL-1:0] iretire_o;
   logic              ilastsize_o;
   logic [3:0]        itype_o;
   logic [1:0]        priv_o;

   mure_iretire_sequencer #(.XLEN(32), .IRETIRE_LEN(TB_IRL)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .fifo_empty_i  (fifo_empty_i),
      .fifo_entry_i  (fifo_entry_i),
      .fifo_pop_o    (fifo_pop_o),
      .block_valid_o (block_valid_o),
      .block_ready_i (block_ready_i),
      .iaddr_o       (iaddr_o),
      .iretire_o     (iretire_o),
      .ilastsize_o   (ilastsize_o),
      .itype_o       (itype_o),
      .priv_o        (priv_o)
   );

   always #5 clk_i = ~clk_i;

   int         checks = 0;
   int         errors = 0;
   uop_entry_s fifo_q[$];
   blk_t       exp_q[$];
   blk_t       hs_log[$];
   int         hs_cyc[$];
   int         cyc = 0;
   int         pop_cnt = 0;
   int         blk_cnt = 0;
   int         first_valid_pops = -1;
   int         ready_mode = 1;
   bit         last_pop = 1'b0;

   bit          m_in = 1'b0;
   logic [31:0] m_iaddr;
   int          m_acc;
   logic        m_last;
   logic [1:0]  m_priv;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic uop_entry_s mk(input bit v, input logic [31:0] pc, input itype_e it,
                                     input bit c, input logic [1:0] p);
      uop_entry_s e;
      e.valid      = v;
      e.pc         = pc;
      e.itype      = it;
      e.compressed = c;
      e.priv       = p;
      return e;
   endfunction

   // Blocks as a function of the retired-instruction stream alone.
   function automatic void model_push(input uop_entry_s e);
      int sz;
      bit split;
      if (!e.valid) return;
      sz    = e.compressed ? 1 : 2;
      split = 1'b0;
      if (m_in) begin
`ifdef MURE_PRIV_SPLIT_EN
         split = (e.priv != m_priv);
`endif
         if (m_acc + 2 > ACC_MAX || split) begin
            exp_q.push_back('{m_iaddr, m_acc, m_last, 4'(STD), m_priv});
            m_in = 1'b0;
         end
      end
      if (!m_in) begin
         m_in    = 1'b1;
         m_iaddr = e.pc;
         m_acc   = sz;
         m_priv  = e.priv;
      end else begin
         m_acc = m_acc + sz;
      end
      m_last = !e.compressed;
      if (e.itype != STD) begin
         exp_q.push_back('{m_iaddr, m_acc, m_last, 4'(e.itype), m_priv});
         m_in = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      m_in = 1'b0;
      exp_q.delete();
   endfunction

   function automatic blk_t log_at(input int i);
      blk_t b = '{32'h0, 0, 1'b0, 4'h0, 2'h0};
      if (i < hs_log.size()) b = hs_log[i];
      return b;
   endfunction

   task automatic drive();
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_entry_i = fifo_empty_i ? '0 : fifo_q[0];
   endtask

   task automatic push(input uop_entry_s e);
      fifo_q.push_back(e);
      model_push(e);
      drive();
   endtask

   task automatic clear_log();
      hs_log.delete();
      hs_cyc.delete();
      first_valid_pops = -1;
      pop_cnt = 0;
   endtask

   task automatic cycle();
      blk_t got, e;
      @(negedge clk_i);
      cyc++;
      if (rst_i || fifo_empty_i || (block_valid_o && !block_ready_i))
         check_val("pop_gate", 64'(fifo_pop_o), 64'd0);
      if (!rst_i && block_valid_o && block_ready_i) begin
         got = '{iaddr_o, int'(iretire_o), ilastsize_o, itype_o, priv_o};
         hs_log.push_back(got);
         hs_cyc.push_back(cyc);
         blk_cnt++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_blk", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_val("blk_iaddr", 64'(got.iaddr), 64'(e.iaddr));
            check_val("blk_iretire", 64'(got.iretire), 64'(e.iretire));
            check_val("blk_ilastsize", 64'(got.last), 64'(e.last));
            check_val("blk_itype", 64'(got.itype), 64'(e.itype));
            check_val("blk_priv", 64'(got.priv), 64'(e.priv));
         end
      end
      if (block_valid_o && first_valid_pops < 0) first_valid_pops = pop_cnt;
      last_pop = fifo_pop_o;
      if (fifo_pop_o) pop_cnt++;
      @(posedge clk_i);
      #1;
      if (last_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      case (ready_mode)
         0:       block_ready_i = 1'b0;
         1:       block_ready_i = 1'b1;
         default: block_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      drive();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400; i++) begin
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !block_valid_o) break;
         cycle();
      end
      check_val(tag, 64'(fifo_q.size() + exp_q.size()), 64'd0);
   endtask

   task automatic do_reset(input int n);
      rst_i = 1'b1;
      repeat (n) cycle();
      rst_i = 1'b0;
      model_reset();
      drive();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      blk_t b;
      int   blk_before;
      int   n;
      rst_i         = 1'b1;
      block_ready_i = 1'b1;
      fifo_q.push_back(mk(1'b1, 32'h10, TB, 1'b0, 2'd3));
      fifo_q.push_back(mk(1'b1, 32'h14, EXC, 1'b1, 2'd1));
      drive();

      // Reset with a non-empty FIFO and a ready encoder.
      repeat (3) begin
         cycle();
         check_val("rst_valid", 64'(block_valid_o), 64'd0);
         check_val("rst_iaddr", 64'(iaddr_o), 64'd0);
         check_val("rst_iretire", 64'(iretire_o), 64'd0);
         check_val("rst_ilastsize", 64'(ilastsize_o), 64'd0);
         check_val("rst_itype", 64'(itype_o), 64'(STD));
         check_val("rst_priv", 64'(priv_o), 64'd0);
      end
      fifo_q.delete();
      rst_i = 1'b0;
      model_reset();
      drive();
      cycle();

      // Basic block.
      clear_log();
      push(mk(1'b1, 32'h1000, STD, 1'b0, 2'd3));
      push(mk(1'b1, 32'h1004, STD, 1'b0, 2'd3));
      push(mk(1'b1, 32'h1008, STD, 1'b0, 2'd3));
      push(mk(1'b1, 32'h100C, TB, 1'b1, 2'd3));
      drain("basic_drain");
      b = log_at(0);
      check_val("basic_count", 64'(hs_log.size()), 64'd1);
      check_val("basic_latency", 64'(first_valid_pops), 64'd4);
      check_val("basic_iaddr", 64'(b.iaddr), 64'h1000);
      check_val("basic_iretire", 64'(b.iretire), 64'd7);
      check_val("basic_ilastsize", 64'(b.last), 64'd0);
      check_val("basic_itype", 64'(b.itype), 64'(TB));

      // Single-entry blocks, back to back.
      clear_log();
      push(mk(1'b1, 32'h2000, EXC, 1'b0, 2'd3));
      push(mk(1'b1, 32'h0080, ERET, 1'b1, 2'd3));
      drain("single_drain");
      check_val("single_count", 64'(hs_log.size()), 64'd2);
      b = log_at(0);
      check_val("single0_iretire", 64'(b.iretire), 64'd2);
      check_val("single0_ilastsize", 64'(b.last), 64'd1);
      check_val("single0_itype", 64'(b.itype), 64'(EXC));
      b = log_at(1);
      check_val("single1_iretire", 64'(b.iretire), 64'd1);
      check_val("single1_ilastsize", 64'(b.last), 64'd0);
      check_val("single1_itype", 64'(b.itype), 64'(ERET));
      if (hs_cyc.size() == 2) check_val("single_b2b", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
      else check_val("single_b2b_count", 64'(hs_cyc.size()), 64'd2);

      // Backpressure.
      clear_log();
      ready_mode    = 0;
      block_ready_i = 1'b0;
      push(mk(1'b1, 32'h3000, EXC, 1'b0, 2'd1));
      push(mk(1'b1, 32'h3010, TB, 1'b1, 2'd1));
      for (int i = 0; i < 10; i++) begin
         if (block_valid_o) break;
         cycle();
      end
      check_val("bp_valid", 64'(block_valid_o), 64'd1);
      repeat (5) begin
         cycle();
         check_val("bp_hold_valid", 64'(block_valid_o), 64'd1);
         check_val("bp_hold_iaddr", 64'(iaddr_o), 64'h3000);
         check_val("bp_hold_iretire", 64'(iretire_o), 64'd2);
         check_val("bp_hold_itype", 64'(itype_o), 64'(EXC));
         check_val("bp_hold_pop", 64'(last_pop), 64'd0);
      end
      ready_mode    = 1;
      block_ready_i = 1'b1;
      cycle();
      check_val("bp_resume_pop", 64'(last_pop), 64'd1);
      drain("bp_drain");
      check_val("bp_count", 64'(hs_log.size()), 64'd2);

      // Privilege change inside a block.
      clear_log();
      push(mk(1'b1, 32'h0100, STD, 1'b0, 2'd3));
      push(mk(1'b1, 32'h0104, STD, 1'b0, 2'd3));
      push(mk(1'b1, 32'h0200, STD, 1'b0, 2'd0));
      push(mk(1'b1, 32'h0204, NTB, 1'b0, 2'd0));
      drain("priv_drain");
`ifdef MURE_PRIV_SPLIT_EN
      check_val("priv_count", 64'(hs_log.size()), 64'd2);
      b = log_at(0);
      check_val("priv0_iaddr", 64'(b.iaddr), 64'h100);
      check_val("priv0_iretire", 64'(b.iretire), 64'd4);
      check_val("priv0_itype", 64'(b.itype), 64'(STD));
      check_val("priv0_priv", 64'(b.priv), 64'd3);
      b = log_at(1);
      check_val("priv1_iaddr", 64'(b.iaddr), 64'h200);
      check_val("priv1_iretire", 64'(b.iretire), 64'd4);
      check_val("priv1_itype", 64'(b.itype), 64'(NTB));
      check_val("priv1_priv", 64'(b.priv), 64'd0);
`else
      check_val("priv_count", 64'(hs_log.size()), 64'd1);
      b = log_at(0);
      check_val("priv_iaddr", 64'(b.iaddr), 64'h100);
      check_val("priv_iretire", 64'(b.iretire), 64'd8);
      check_val("priv_itype", 64'(b.itype), 64'(NTB));
      check_val("priv_priv", 64'(b.priv), 64'd3);
`endif

      // Counter saturation with a 4-bit iretire.
      clear_log();
      for (int i = 0; i < 8; i++) push(mk(1'b1, 32'h4000 + 32'(4 * i), STD, 1'b0, 2'd3));
      push(mk(1'b1, 32'h4020, TB, 1'b1, 2'd3));
      drain("sat_drain");
      check_val("sat_pops", 64'(first_valid_pops), 64'd7);
      b = log_at(0);
      check_val("sat0_iretire", 64'(b.iretire), 64'd14);
      check_val("sat0_itype", 64'(b.itype), 64'(STD));
      check_val("sat0_ilastsize", 64'(b.last), 64'd1);
      b = log_at(1);
      check_val("sat1_iaddr", 64'(b.iaddr), 64'h401C);
      check_val("sat1_iretire", 64'(b.iretire), 64'd3);

      // Reset in the middle of a block discards it.
      clear_log();
      blk_before = blk_cnt;
      push(mk(1'b1, 32'h5000, STD, 1'b0, 2'd3));
      push(mk(1'b1, 32'h5004, STD, 1'b1, 2'd3));
      push(mk(1'b1, 32'h5006, STD, 1'b0, 2'd3));
      drain("midrst_fill");
      do_reset(2);
      repeat (3) cycle();
      check_val("midrst_noblk", 64'(blk_cnt - blk_before), 64'd0);
      push(mk(1'b1, 32'h6000, TB, 1'b1, 2'd3));
      drain("midrst_drain");
      b = log_at(0);
      check_val("midrst_iaddr", 64'(b.iaddr), 64'h6000);
      check_val("midrst_iretire", 64'(b.iretire), 64'd1);

      // Random streams with random encoder backpressure.
      ready_mode = 2;
      for (int s = 0; s < 30; s++) begin
         n = $urandom_range(1, 14);
         for (int k = 0; k < n; k++) begin
            int      r;
            itype_e  it;
            logic [1:0] p;
            r  = $urandom_range(0, 9);
            it = (r < 6) ? STD : itype_e'(r - 5);
            p  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
            push(mk($urandom_range(0, 9) != 0, $urandom & 32'hFFFF_FFFE, it,
                    1'($urandom_range(0, 1)), p));
            if ($urandom_range(0, 3) == 0) cycle();
         end
         push(mk(1'b1, $urandom & 32'hFFFF_FFFE, TB, 1'($urandom_range(0, 1)), 2'd3));
         drain("rand_drain");
      end

      check_val("exp_left", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
